seq_detector: RTL and testbench
===============================

# seq_detector

Parametrised serial pattern detector: the generalised successor of the team's fixed 3-bit sequence FSMs. It samples one bit per valid cycle on `w` and compares a run-time loadable pattern of 1..`MAX_LEN` bits against the most recent bits. It asserts a registered one-cycle `z` pulse on each match, with selectable overlapping or non-overlapping detection and an optional saturating match counter. It sits behind any serial bit source in lab/datapath designs that previously instantiated a hard-coded detector.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width.
- `LEN_W`, `$clog2(MAX_LEN+1)`: derived width of `len`; not overridden.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `load` in 1: latch `pattern`, `len`, `overlap`; clear history.
- `pattern` in `MAX_LEN`: `pattern[len-1]` is the first bit expected, `pattern[0]` the last.
- `len` in `LEN_W`: active pattern length.
- `overlap` in 1: 1 = overlapping matches allowed; 0 = history cleared after a match.
- `w` in 1: serial data bit.
- `w_valid` in 1: `w` is sampled only when high.
- `z` out 1: registered match pulse.
- `busy` out 1: high in the FILL or RUN state.
- `match_count` out `CNT_W`: saturating match count; present only with the counter compiled in.

## Operation
- Latched config registers: `pat_q`, `len_q`, `ovl_q`.
- History shift register `hist[MAX_LEN-1:0]`: on each accepted bit, `hist <= {hist[MAX_LEN-2:0], w}`, so the newest bit is at `hist[0]`.
- Fill counter `fill` (`LEN_W` bits) counts accepted bits since the last clear and saturates at `len_q`.
- FSM states:
  - IDLE: no valid pattern; bits are ignored.
  - FILL: fewer than `len_q` bits held.
  - RUN: at least `len_q` bits held.
- Transitions:
  - `load` with `len` = 0: go to IDLE.
  - `load` with `len` ≥ 1: go to FILL. `len` > `MAX_LEN` is clamped to `MAX_LEN`. `hist` and `fill` clear to 0.
  - FILL → RUN when the accepted bit makes `fill` reach `len_q`.
  - Non-overlap match: RUN or FILL → FILL, with `hist` and `fill` cleared.
  - `overlap` = 1: remain in RUN after a match.
- Match condition: an accepted bit completes a match when the updated history's low `len_q` bits equal `pat_q`'s low `len_q` bits, and the updated fill count is ≥ `len_q`.
- Evaluation is on the next-history value, so a match is detected on the accepted bit itself.
- In non-overlap mode, the bit that completes a match is not reused as the first bit of a new match.
- Precedence, highest first: `reset` > `load` > `w_valid`. A bit presented in the same cycle as `load` is discarded.
- Counter: increments on each match and saturates at 2^`CNT_W`−1. `load` does not clear it; only `reset` does.

## Timing
- Reset values: `z` = 0, `busy` = 0, `match_count` = 0, state = IDLE, all registers 0.
- Latency: the bit that completes the pattern is accepted at edge N; `z` = 1 during the cycle after edge N, for exactly one cycle.
- `match_count` updates at the same edge as `z`.
- No back-to-back restriction: in overlap mode with `len` = 1, `z` may be high on consecutive cycles.
- `w_valid` = 0: `hist`, `fill` and state hold; `z` returns to 0 at the next edge.
- `reset` asserted mid-stream: all state is lost at that edge, and the pattern must be reloaded.
- `busy` reflects the registered state.

## Configuration
- `SEQ_DETECTOR_COUNT_EN` defined: the `match_count` port and the saturating counter are present.
- `SEQ_DETECTOR_COUNT_EN` undefined: the port and logic are absent; all other behaviour is identical.

## Structure
- Package `seq_detector_pkg`:
  - State enum `seq_state_t` {IDLE, FILL, RUN}.
  - Encoding constants.
  - Function `clamp_len`.
- One sub-module, `seq_hist_shift`: the `MAX_LEN`-bit history register with enable and synchronous clear.
- The top module owns the FSM, comparator, fill counter and counter.

## Test plan
- Overlap, `len` = 3, `pattern` = 3'b101, stream 1,0,1,0,1 → `z` pulses after the 3rd and 5th bits; `match_count` = 2.
- Non-overlap, same pattern and stream → `z` pulses after the 3rd bit only; `match_count` = 1; state is FILL after the 5th bit with `fill` = 2.
- `len` = 8, `pattern` = 8'hA5, stream with `w_valid` gaps inserted → gaps do not break the match; one `z` pulse after the 8th valid bit.
- `load` `len` = 0 → IDLE; 20 bits of 1 → no `z` pulses, `busy` = 0. Then `load` `len` = 12 with `MAX_LEN` = 8 → clamped to 8.
- `load` and `w_valid` in the same cycle → the bit is discarded and `fill` = 0. Then `reset` mid-FILL → IDLE, `z` = 0, counter = 0.
- `CNT_W` = 2, overlap, `len` = 1, `pattern` = 1, with five consecutive 1 bits → `match_count` saturates at 3; `z` high for 5 consecutive cycles.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the seq_detector serial pattern detector.
// Optional match counter is enabled by defining SEQ_DETECTOR_COUNT_EN.
package seq_detector_pkg;

    localparam int unsigned SEQ_STATE_W = 2;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// History shift register for seq_detector: newest accepted bit enters at hist[0].
// Synchronous reset and clear take priority over the shift enable.
module seq_hist_shift #(
    parameter int unsigned MAX_LEN = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic               bit_in,
    output logic [MAX_LEN-1:0] hist
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist <= '0;
        end else if (en) begin
            hist <= {hist[MAX_LEN-2:0], bit_in};
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Run-time loadable serial pattern detector with overlapping/non-overlapping matches.
// Define SEQ_DETECTOR_COUNT_EN to add the saturating match_count output.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               w,
    input  logic               w_valid,
    output logic               z,
    output logic               busy
`ifdef SEQ_DETECTOR_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    if (MAX_LEN < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("seq_detector: MAX_LEN must be >= 2 and CNT_W >= 1");
    end

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic [MAX_LEN-1:0] hist, hist_next, mask, ones;
    logic               accept, hit, hist_clr, hist_en;

    seq_hist_shift #(
        .MAX_LEN(MAX_LEN)
    ) u_hist (
        .clock (clock),
        .reset (reset),
        .clear (hist_clr),
        .en    (hist_en),
        .bit_in(w),
        .hist  (hist)
    );

    // Match is judged on the history as it will be after this bit is shifted in.
    always_comb begin
        ones      = '1;
        mask      = ~(ones << len_q);
        hist_next = {hist[MAX_LEN-2:0], w};
        accept    = w_valid && !load && (state_q != IDLE);
        fill_inc  = (fill_q < len_q) ? LEN_W'(fill_q + 1'b1) : fill_q;
        hit       = accept && (((hist_next ^ pat_q) & mask) == '0) && (fill_inc >= len_q);
    end

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        hist_clr = 1'b0;
        hist_en  = 1'b0;
        if (load) begin
            hist_clr = 1'b1;
            fill_d   = '0;
            state_d  = (len == '0) ? IDLE : FILL;
        end else if (accept) begin
            if (hit && !ovl_q) begin
                hist_clr = 1'b1;
                fill_d   = '0;
                state_d  = FILL;
            end else begin
                hist_en = 1'b1;
                fill_d  = fill_inc;
                state_d = (fill_inc >= len_q) ? RUN : FILL;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            z       <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            z       <= hit;
            if (load) begin
                pat_q <= pattern;
                len_q <= LEN_W'(clamp_len(int'(len), MAX_LEN));
                ovl_q <= overlap;
            end
        end
    end

    assign busy = (state_q != IDLE);

`ifdef SEQ_DETECTOR_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: queue-based reference model plus directed scenarios.
module tb_seq_detector;
    import seq_detector_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic       overlap = 1'b0;
    logic       w = 1'b0;
    logic       w_valid = 1'b0;
    logic       z, busy;
`ifdef SEQ_DETECTOR_COUNT_EN
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic       z2, busy2;
`endif

    always #5 clock = ~clock;

    seq_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .load(load), .pattern(pattern), .len(len),
        .overlap(overlap), .w(w), .w_valid(w_valid), .z(z), .busy(busy)
`ifdef SEQ_DETECTOR_COUNT_EN
        , .match_count(match_count)
`endif
    );

`ifdef SEQ_DETECTOR_COUNT_EN
    seq_detector #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .load(load), .pattern(pattern), .len(len),
        .overlap(overlap), .w(w), .w_valid(w_valid), .z(z2), .busy(busy2),
        .match_count(match_count2)
    );
`endif

    int checks = 0;
    int errors = 0;
    int zseen  = 0;
    bit chk_en = 0;

    // Reference model: bits accepted since the last clear, newest at the back.
    bit       m_active = 0;
    int       m_len = 0;
    bit [7:0] m_pat = '0;
    bit       m_ovl = 0;
    bit       m_z = 0;
    int       m_cnt = 0;
    int       m_cnt2 = 0;
    bit       q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_fill();
        if (!m_active) return 0;
        return (q.size() < m_len) ? q.size() : m_len;
    endfunction

    task automatic model_step();
        bit hitm;
        if (reset) begin
            m_active = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_z = 0;
            m_cnt = 0; m_cnt2 = 0; q.delete();
        end else if (load) begin
            m_len    = (len > 8) ? 8 : int'(len);
            m_active = (len != 0);
            m_pat    = pattern;
            m_ovl    = overlap;
            m_z      = 0;
            q.delete();
        end else if (w_valid && m_active) begin
            q.push_back(w);
            hitm = (q.size() >= m_len);
            for (int i = 0; i < m_len; i++)
                if (hitm && q[q.size()-1-i] != m_pat[i]) hitm = 0;
            m_z = hitm;
            if (hitm) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) q.delete();
            end
            if (q.size() > 16) void'(q.pop_front());
        end else begin
            m_z = 0;
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("z", 32'(z), 32'(m_z));
            chk("busy", 32'(busy), 32'(m_active));
            chk("fill", 32'(dut.fill_q), 32'(exp_fill()));
`ifdef SEQ_DETECTOR_COUNT_EN
            chk("match_count", 32'(match_count), 32'(m_cnt));
            chk("match_count_w2", 32'(match_count2), 32'(m_cnt2));
`endif
            if (z === 1'b1) zseen++;
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        chk_en = 1;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] p, input int l, input bit ovl,
                           input bit wv = 0, input bit wb = 0);
        load = 1'b1; pattern = p; len = 4'(l); overlap = ovl; w_valid = wv; w = wb;
        tick();
        load = 1'b0; w_valid = 1'b0;
    endtask

    task automatic send(input bit b);
        w = b; w_valid = 1'b1; tick(); w_valid = 1'b0;
    endtask

    task automatic gap();
        w_valid = 1'b0; tick();
    endtask

    int z0;
    logic [7:0] a5;

    initial begin
        do_reset();
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_z", 32'(z), 32'd0);

        // Overlap, 101 over 1,0,1,0,1
        do_load(8'b101, 3, 1);
        z0 = zseen;
        send(1); send(0); send(1); send(0); send(1);
        chk("t1_pulses", 32'(zseen - z0), 32'd2);
`ifdef SEQ_DETECTOR_COUNT_EN
        chk("t1_count", 32'(match_count), 32'd2);
`endif

        // Non-overlap, same stream
        do_reset();
        do_load(8'b101, 3, 0);
        z0 = zseen;
        send(1); send(0); send(1); send(0); send(1);
        chk("t2_pulses", 32'(zseen - z0), 32'd1);
        chk("t2_fill", 32'(dut.fill_q), 32'd2);
        chk("t2_state", 32'(dut.state_q), 32'(FILL));
`ifdef SEQ_DETECTOR_COUNT_EN
        chk("t2_count", 32'(match_count), 32'd1);
`endif

        // len 8, A5, with gaps between valid bits
        do_load(8'hA5, 8, 0);
        z0 = zseen;
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send(a5[i]);
            if (i % 2 == 1) begin gap(); gap(); end
        end
        gap();
        chk("t3_pulses", 32'(zseen - z0), 32'd1);

        // len 0 -> IDLE, bits ignored
        do_load(8'hFF, 0, 1);
        z0 = zseen;
        for (int i = 0; i < 20; i++) send(1);
        chk("t4_pulses", 32'(zseen - z0), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // len 12 clamps to 8
        do_load(8'hFF, 12, 1);
        chk("t4_len_clamp", 32'(dut.len_q), 32'd8);
        z0 = zseen;
        for (int i = 0; i < 9; i++) send(1);
        chk("t4_clamp_pulses", 32'(zseen - z0), 32'd2);

        // load with a simultaneous valid bit discards the bit
        do_load(8'b110, 3, 1, 1, 1);
        chk("t5_fill_after_load", 32'(dut.fill_q), 32'd0);
        send(1); send(1);
        chk("t5_fill_mid", 32'(dut.fill_q), 32'd2);
        do_reset();
        chk("t5_reset_busy", 32'(busy), 32'd0);
        chk("t5_reset_z", 32'(z), 32'd0);
        chk("t5_reset_state", 32'(dut.state_q), 32'(IDLE));
`ifdef SEQ_DETECTOR_COUNT_EN
        chk("t5_reset_count", 32'(match_count), 32'd0);
`endif

        // len 1 overlap: z on consecutive cycles, narrow counter saturates
        do_load(8'h01, 1, 1);
        z0 = zseen;
        for (int i = 0; i < 5; i++) send(1);
        chk("t6_pulses", 32'(zseen - z0), 32'd5);
`ifdef SEQ_DETECTOR_COUNT_EN
        chk("t6_count", 32'(match_count), 32'd5);
        chk("t6_count_sat", 32'(match_count2), 32'd3);
`endif
        gap();
        chk("t6_z_drop", 32'(z), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
